spi_xfer_arbiter: RTL and testbench
===================================

// Module: spi_xfer_arbiter
// PURPOSE
//  Shares one 32-bit SPI master between N_REQ requesters with round-robin arbitration.
//  Latches the granted requester's word and per-requester mode (CPOL/CPHA/divider/slave)
//  and drives the master's start/config/slave-select inputs for one full-duplex transfer.
//  Returns the received word to the owner and enforces a CS-high guard gap between transfers.
//  Sits between bus-side client ports and the SPI master instance.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  DW       32   transfer width; must match master shift register
//  GAP_CYC  4    clk cycles in GAP state (CS high) between transfers, >=1
//  TO_CYC   4096 XFER timeout in clk cycles; 0 disables timeout
// PORTS
//  clk        in   1          system clock, all logic on posedge
//  reset      in   1          asynchronous, active-low reset
//  req        in   N_REQ      level request per requester; hold until its ack
//  req_data   in   N_REQ*DW   TX word, requester k at [k*DW +: DW]
//  req_cfg    in   N_REQ*8    k: [7]=cpol [6]=cpha [5:2]=dvsr [1:0]=slave idx
//  ack        out  N_REQ      one-cycle one-hot pulse: transfer for k finished
//  rsp_data   out  DW         RX word, valid in ack cycle, held until next ack
//  rsp_err    out  1          valid with ack: 1 = timeout abort
//  busy       out  1          high in any state except IDLE
//  m_start    out  1          master start/enable; high only in XFER
//  m_cpol     out  1          latched cpol
//  m_cpha     out  1          latched cpha
//  m_dvsr     out  4          latched dvsr
//  m_sel      out  2          latched slave index (master's cs select)
//  m_data_in  out  DW         latched TX word
//  m_data_out in   DW         master RX shift register
//  m_done     in   1          one-cycle pulse from master when DW bits completed
// BEHAVIOUR
//  Reset (reset=0, any state): state=IDLE, ptr=0, ack=0, rsp_data=0, rsp_err=0,
//   busy=0, m_start=0, m_cpol/m_cpha/m_dvsr/m_sel/m_data_in=0, counters=0. Mid-transfer
//   reset aborts with no ack; master sees m_start=0 immediately.
//  States: IDLE -> SETUP -> XFER -> GAP -> IDLE.
//  IDLE: if |req, pick first asserted index at or after ptr (wrap mod N_REQ); register
//   owner, latch req_data/req_cfg into m_* regs; go SETUP next cycle. Else stay.
//  SETUP: exactly 1 cycle, m_start=0, config stable so master's SCLK idles at new CPOL
//   before start; -> XFER.
//  XFER: m_start=1; cnt increments each cycle. m_done=1 -> rsp_data<=m_data_out,
//   rsp_err<=0, ack[owner]<=1 (next cycle), -> GAP. cnt==TO_CYC-1 (TO_CYC!=0) without
//   m_done -> rsp_data<=0, rsp_err<=1, ack[owner]<=1, -> GAP. m_done wins if both same cycle.
//  GAP: m_start=0 for GAP_CYC cycles (master returns to IDLE, CS high); ptr<=owner+1
//   mod N_REQ on entry; -> IDLE. New grant earliest in the cycle after GAP ends.
//  Latency: req seen in IDLE cycle t -> m_start high at t+2; ack one cycle after m_done.
//  Config/data inputs ignored outside the IDLE grant cycle; mid-transfer changes no effect.
//  req dropped by owner during XFER: transfer still completes, ack still issued.
//  m_done outside XFER ignored. ack is never asserted for more than one cycle or index.
//  Fairness: with all req high, grants cycle 0,1,..,N_REQ-1,0; no requester waits more
//   than N_REQ-1 transfers.
//  Counter widths: cnt = clog2(TO_CYC+1) bits; gap counter = clog2(GAP_CYC+1) bits.
// TESTING
//  1 req=0001, data0=A5A5_0F0F, cfg0=8'h00, master loopback -> m_start rises 2 cycles
//    after req; ack=0001 1 cycle after m_done; rsp_data=A5A5_0F0F, rsp_err=0.
//  2 req=1111 held, 8 transfers -> ack order 0,1,2,3,0,1,2,3; m_start low >=GAP_CYC+1
//    cycles between transfers.
//  3 cfg1=8'hC7 (cpol=1,cpha=1,dvsr=1,sel=3) -> m_cpol=1,m_cpha=1,m_dvsr=1,m_sel=3
//    in SETUP, stable through XFER; req_cfg changed mid-XFER -> m_* unchanged.
//  4 TO_CYC=64, m_done never asserted -> ack at cycle 64 of XFER, rsp_err=1, rsp_data=0;
//    next requester then served normally.
//  5 reset pulsed low mid-XFER -> all outputs 0 asynchronously, no ack; after release
//    req still high -> fresh grant starting at index 0.
//  6 m_done and timeout in same cycle -> rsp_err=0, rsp_data=m_data_out.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that lends one SPI master to N_REQ requesters, one full-duplex
// word at a time, with a CS-high guard gap after every transfer.
module spi_xfer_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DW      = 32,
  parameter int GAP_CYC = 4,
  parameter int TO_CYC  = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*DW-1:0] req_data,
  input  logic [N_REQ*8-1:0] req_cfg,
  output logic [N_REQ-1:0]   ack,
  output logic [DW-1:0]      rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               m_start,
  output logic               m_cpol,
  output logic               m_cpha,
  output logic [3:0]         m_dvsr,
  output logic [1:0]         m_sel,
  output logic [DW-1:0]      m_data_in,
  input  logic [DW-1:0]      m_data_out,
  input  logic               m_done,
  output logic [1:0]         dbg_state
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam bit TO_EN = (TO_CYC != 0);
  localparam logic [CW-1:0]    TO_LAST  = CW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
  localparam logic [GW-1:0]    GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [IW:0]      N_W      = (IW + 1)'(N_REQ);
  localparam logic [IW-1:0]    LAST_IDX = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;

  state_t        state;
  logic [IW-1:0] ptr, owner, gnt_idx, nxt_ptr;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          gnt_found;
  logic [IW:0]   sum;
  logic [7:0]    gnt_cfg;
  logic [DW-1:0] gnt_data;
  logic          xfer_end;

  // Handshake: a requester holds req high (and its word/cfg stable) until it sees its
  // one-cycle ack pulse; the word and cfg are only sampled in the IDLE grant cycle.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IW + 1)'(i);
      if (sum >= N_W) sum = sum - N_W;
      if (!gnt_found && req[sum[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = sum[IW-1:0];
      end
    end
  end

  assign gnt_cfg   = req_cfg[gnt_idx*8 +: 8];
  assign gnt_data  = req_data[gnt_idx*DW +: DW];
  assign nxt_ptr   = (owner == LAST_IDX) ? '0 : owner + 1'b1;
  // A master completion takes priority over a timeout landing in the same cycle.
  assign xfer_end  = m_done || (TO_EN && (cnt == TO_LAST));
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      ack       <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      m_start   <= 1'b0;
      m_cpol    <= 1'b0;
      m_cpha    <= 1'b0;
      m_dvsr    <= '0;
      m_sel     <= '0;
      m_data_in <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            owner     <= gnt_idx;
            m_cpol    <= gnt_cfg[7];
            m_cpha    <= gnt_cfg[6];
            m_dvsr    <= gnt_cfg[5:2];
            m_sel     <= gnt_cfg[1:0];
            m_data_in <= gnt_data;
            state     <= SETUP;
          end
        end
        SETUP: begin
          m_start <= 1'b1;
          cnt     <= '0;
          state   <= XFER;
        end
        XFER: begin
          if (xfer_end) begin
            rsp_data <= m_done ? m_data_out : '0;
            rsp_err  <= !m_done;
            ack      <= ONE << owner;
            m_start  <= 1'b0;
            gcnt     <= '0;
            ptr      <= nxt_ptr;
            state    <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (gcnt == GAP_LAST) state <= IDLE;
          else                  gcnt  <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Bench for spi_xfer_arbiter: directed corner sequences, a vector table and randomized
// rounds checked against a round-robin model and a simple loopback SPI master.
module tb_spi_xfer_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int GAP = 4;
  localparam int TO  = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N*8-1:0]  req_cfg = '0;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err, busy, m_start, m_cpol, m_cpha;
  logic [3:0]      m_dvsr;
  logic [1:0]      m_sel;
  logic [DW-1:0]   m_data_in;
  logic [DW-1:0]   m_data_out = '0;
  logic            m_done;
  logic [1:0]      dbg_state;
  logic            md_model = 1'b0, md_stray = 1'b0;
  logic [39:0]     m_view;

  int              lat_cfg = 0;
  logic [DW-1:0]   rx_xor = '0;
  int              xc_m = 0;
  int              n_vec = 0, n_err = 0;
  logic [DW-1:0]   exp_q[$];
  logic [DW-1:0]   last_rsp = '0;

  assign m_done = md_model | md_stray;
  assign m_view = {m_cpol, m_cpha, m_dvsr, m_sel, m_data_in};

  always #5 clk = ~clk;

  spi_xfer_arbiter #(.N_REQ(N), .DW(DW), .GAP_CYC(GAP), .TO_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_cfg(req_cfg),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .m_start(m_start),
    .m_cpol(m_cpol), .m_cpha(m_cpha), .m_dvsr(m_dvsr), .m_sel(m_sel),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_done(m_done), .dbg_state(dbg_state)
  );

  // Loopback master: pulses done in the lat_cfg-th cycle of m_start (never if 0).
  always @(negedge clk) begin
    if (m_start) begin
      xc_m = xc_m + 1;
      md_model = (lat_cfg != 0) && (xc_m == lat_cfg);
    end else begin
      xc_m = 0;
      md_model = 1'b0;
    end
    m_data_out = m_data_in ^ rx_xor;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] mask, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (mask[j]) return j;
    end
    return -1;
  endfunction

  task automatic run_round(input logic [N-1:0] mask, input int lat, input logic [DW-1:0] xr,
                           input bit drop, input bit chg, input bit b2b, input int exp_own,
                           input bit exp_err, output int rise);
    logic [39:0]   exp_m;
    logic [DW-1:0] exp_rsp;
    int            xc, low, exp_xc;
    bit            started, got;
    req     = mask;
    lat_cfg = lat;
    rx_xor  = xr;
    exp_m   = {req_cfg[exp_own*8 +: 8], req_data[exp_own*DW +: DW]};
    exp_rsp = exp_err ? '0 : (req_data[exp_own*DW +: DW] ^ xr);
    exp_q.push_back(exp_rsp);
    exp_xc  = (lat >= 1 && lat <= TO) ? lat : TO;
    started = 0; got = 0; xc = 0; low = 0; rise = 0;
    for (int c = 1; c <= 400 && !got; c++) begin
      @(negedge clk);
      if (!started) begin
        if (m_start) begin
          started = 1; xc = 1; rise = c;
          chk("cfg_xfer_start", m_view, exp_m);
          if (b2b) chk("gap_low_cycles", low + 2, GAP + 2);
          if (drop) req[exp_own] = 1'b0;
          if (chg) begin
            req_cfg  = ~req_cfg;
            req_data = ~req_data;
          end
        end else begin
          low++;
          if (dbg_state == 2'd1) chk("cfg_setup", m_view, exp_m);
        end
      end else if (m_start) begin
        xc++;
      end
      if (ack != '0) got = 1;
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout: got no ack in 400 cycles, want ack for %0d", exp_own);
      void'(exp_q.pop_front());
    end else begin
      chk("ack_onehot", ack, 4'b0001 << exp_own);
      chk("m_start_low_at_ack", m_start, 0);
      chk("xfer_cycles", xc, exp_xc);
      last_rsp = exp_q.pop_front();
      chk("rsp_data", rsp_data, last_rsp);
      chk("rsp_err", rsp_err, exp_err);
      chk("cfg_held", m_view, exp_m);
      @(negedge clk);
      chk("ack_single_pulse", ack, 0);
    end
  endtask

  typedef struct {
    logic [N-1:0]  mask;
    int            lat;
    logic [DW-1:0] xr;
    bit            drop;
    int            own;
    bit            err;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int rise, m_ptr, own, lat, r;
    logic [N-1:0] mask;
    bit err, drop, seen;
    logic [DW-1:0] xr;

    tbl[0] = '{4'hF,  3, 32'h0,        0, 0, 0};
    tbl[1] = '{4'hF, 12, 32'hFFFF0000, 0, 1, 0};
    tbl[2] = '{4'hF, 64, 32'h1,        1, 2, 0};
    tbl[3] = '{4'hF,  1, 32'h0,        0, 3, 0};
    tbl[4] = '{4'hF, 70, 32'h0,        0, 0, 1};
    tbl[5] = '{4'hF,  9, 32'h12345678, 0, 1, 0};
    tbl[6] = '{4'hF,  0, 32'h0,        0, 2, 1};
    tbl[7] = '{4'hF, 20, 32'h0F0F0F0F, 0, 3, 0};

    // Clock/reset
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ack, rsp_data, rsp_err, busy, m_start, m_view, dbg_state}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_after_release", {ack, busy, m_start, dbg_state}, 0);

    for (int k = 0; k < N; k++) begin
      req_data[k*DW +: DW] = 32'h11111111 * (k + 1);
      req_cfg[k*8 +: 8]    = 8'(8'h10 * k + k);
    end

    // Single requester, loopback, latency to m_start
    req_data[31:0] = 32'hA5A50F0F;
    req_cfg[7:0]   = 8'h00;
    run_round(4'b0001, 8, 32'h0, 0, 0, 0, 0, 0, rise);
    chk("start_latency", rise, 2);
    chk("rsp_t1", rsp_data, 32'hA5A50F0F);
    req = '0;
    repeat (8) @(negedge clk);

    // Config latch, changes during XFER ignored
    req_cfg[15:8]   = 8'hC7;
    req_data[63:32] = 32'h3C3CC3C3;
    run_round(4'b0010, 10, 32'h0, 0, 1, 0, 1, 0, rise);
    chk("cfg_c7", {m_cpol, m_cpha, m_dvsr, m_sel}, {1'b1, 1'b1, 4'd1, 2'd3});
    req_cfg  = ~req_cfg;
    req_data = ~req_data;
    req = '0;
    repeat (8) @(negedge clk);

    // Timeout, then next requester served normally
    run_round(4'b0100, 0, 32'h0, 0, 0, 0, 2, 1, rise);
    run_round(4'b1000, 5, 32'h5A5A5A5A, 0, 0, 1, 3, 0, rise);
    req = '0;
    repeat (8) @(negedge clk);

    // Stray m_done in IDLE
    md_stray = 1'b1;
    @(negedge clk);
    md_stray = 1'b0;
    chk("stray_done_ack", {ack, busy}, 0);
    @(negedge clk);
    chk("stray_done_ack2", {ack, busy}, 0);
    chk("rsp_held", rsp_data, last_rsp);

    // Done and timeout in the same cycle
    run_round(4'b0001, 64, 32'hDEADBEEF, 0, 0, 0, 0, 0, rise);
    req = '0;
    repeat (8) @(negedge clk);

    // Asynchronous reset mid-XFER
    req = 4'hF;
    lat_cfg = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_start) seen = 1;
    end
    chk("reset_test_started", seen, 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("reset_async", {ack, rsp_data, rsp_err, busy, m_start, m_view, dbg_state}, 0);
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_ack", {ack, busy, m_start}, 0);
    end
    reset = 1'b1;

    // Vector table: all requesters held, fairness from index 0
    for (int i = 0; i < 8; i++)
      run_round(tbl[i].mask, tbl[i].lat, tbl[i].xr, tbl[i].drop, 0, (i > 0),
                tbl[i].own, tbl[i].err, rise);

    // Randomized rounds against the round-robin model
    m_ptr = 0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < N; k++) begin
        req_data[k*DW +: DW] = $urandom;
        req_cfg[k*8 +: 8]    = 8'($urandom);
      end
      mask = 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      if (r == 0)      lat = 0;
      else if (r == 1) lat = $urandom_range(TO + 1, TO + 16);
      else if (r == 2) lat = TO;
      else             lat = $urandom_range(1, 20);
      xr   = ($urandom_range(0, 1) == 1) ? $urandom : '0;
      drop = ($urandom_range(0, 3) == 0);
      own  = rr_pick(mask, m_ptr);
      err  = (lat == 0) || (lat > TO);
      m_ptr = (own + 1) % N;
      run_round(mask, lat, xr, drop, 0, 1, own, err, rise);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
